// File: rtl/fp32_max_reduce.sv
// rtl/fp32_max_reduce.sv - streaming FP32 max reducer with argmax over groups of WINDOW words
module fp32_max_reduce #(
    parameter int WINDOW = 4,
    parameter int IDX_W  = $clog2(WINDOW) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WINDOW - 1);

    state_t           state;
    logic [31:0]      acc;
    logic [IDX_W-1:0] accIdx;
    logic [IDX_W-1:0] count;
    logic             nanFlag;

    logic             xfer;
    logic             inNan;
    logic             lastElem;
    logic [31:0]      nxtAcc;
    logic [IDX_W-1:0] nxtIdx;
    logic             nxtNan;

    // Raw bit-pattern ordering: sign-magnitude compare where +0 and -0 tie.
    function automatic logic greaterThan(input logic [31:0] a, input logic [31:0] b);
        logic bothZero;
        bothZero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
        if (a[31] != b[31])
            return !a[31] && !bothZero;
        else if (!a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    // Candidate accumulator update for the element offered this cycle.
    always_comb begin
        xfer     = in_valid && in_ready;
        inNan    = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
        // count is 0 in IDLE, so this also covers single-element windows.
        lastElem = in_last || (count == LAST_POS);
        nxtAcc   = acc;
        nxtIdx   = accIdx;
        nxtNan   = nanFlag;
        if (state == IDLE) begin
            nxtAcc = inNan ? QNAN : in_data;
            nxtIdx = '0;
            nxtNan = inNan;
        end else if (!nanFlag) begin
            // Once a NaN is seen the result and its index are frozen for the group.
            if (inNan) begin
                nxtAcc = QNAN;
                nxtIdx = count;
                nxtNan = 1'b1;
            end else if (greaterThan(in_data, acc)) begin
                nxtAcc = in_data;
                nxtIdx = count;
            end
        end
    end

    // Group FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            acc       <= '0;
            accIdx    <= '0;
            count     <= '0;
            nanFlag   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        acc     <= nxtAcc;
                        accIdx  <= nxtIdx;
                        nanFlag <= nxtNan;
                        if (lastElem) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= nxtAcc;
                            out_index <= nxtIdx;
                            count     <= '0;
                        end else begin
                            state <= ACCUM;
                            count <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        count     <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_max_reduce.sv
// tb/tb_fp32_max_reduce.sv - randomized self-checking bench for fp32_max_reduce
module tb_fp32_max_reduce;

    localparam int WINDOW = 4;
    localparam int IDX_W  = $clog2(WINDOW) + 1;
    localparam int BUDGET = 50;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [IDX_W-1:0] out_index;

    int passCount;
    int totalCount;

    logic [31:0] grp [WINDOW];
    int          grpLen;

    fp32_max_reduce #(.WINDOW(WINDOW), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isNan(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    // Maps a non-NaN float onto the integers so that numeric order is integer order.
    function automatic longint orderKey(input logic [31:0] w);
        longint mag;
        mag = longint'(w[30:0]);
        return w[31] ? -mag : mag;
    endfunction

    task automatic refModel(output logic [31:0] expData, output int expIdx);
        expData = grp[0];
        expIdx  = 0;
        for (int i = 0; i < grpLen; i++) begin
            if (isNan(grp[i])) begin
                expData = 32'h7FC00000;
                expIdx  = i;
                return;
            end
        end
        for (int i = 1; i < grpLen; i++) begin
            if (orderKey(grp[i]) > orderKey(expData)) begin
                expData = grp[i];
                expIdx  = i;
            end
        end
    endtask

    function automatic logic [31:0] randWord();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 15))
            0, 1:    return {s, 31'd0};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
            4, 5:    return {s, 8'h00, 23'($urandom)};
            6:       return {s, 8'h7F, 23'($urandom_range(0, 3))};
            default: return $urandom;
        endcase
    endfunction

    task automatic sendElem(input string name, input logic [31:0] d, input logic last);
        int wait_n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        wait_n   = 0;
        while (!in_ready && wait_n < BUDGET) begin
            @(posedge clk); #1;
            wait_n++;
        end
        if (wait_n >= BUDGET) begin
            totalCount++;
            $display("FAIL %s in_ready timeout: observed 0 for %0d cycles, required 1", name, wait_n);
        end
        @(posedge clk); #1;
    endtask

    // Sends grp[0..grpLen-1], checks the result, then stalls for holdCycles
    // (or, when holdCycles < 0, assumes out_ready is already high).
    task automatic runGroup(input string name, input bit lastOnFinal, input int holdCycles);
        logic [31:0] expData;
        int          expIdx;
        refModel(expData, expIdx);
        for (int i = 0; i < grpLen; i++)
            sendElem(name, grp[i], (i == grpLen - 1) && lastOnFinal);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        totalCount++;
        if (out_valid !== 1'b1) $display("FAIL %s latency out_valid: observed %b, required 1", name, out_valid);
        else passCount++;
        totalCount++;
        if (out_data !== expData) $display("FAIL %s out_data: observed %h, required %h", name, out_data, expData);
        else passCount++;
        totalCount++;
        if (out_index !== IDX_W'(expIdx)) $display("FAIL %s out_index: observed %0d, required %0d", name, out_index, expIdx);
        else passCount++;
        totalCount++;
        if (in_ready !== 1'b0) $display("FAIL %s in_ready in hold: observed %b, required 0", name, in_ready);
        else passCount++;
        if (holdCycles < 0) begin
            @(posedge clk); #1;
            totalCount++;
            if (out_valid !== 1'b0) $display("FAIL %s out_valid after pop: observed %b, required 0", name, out_valid);
            else passCount++;
        end else begin
            for (int h = 0; h < holdCycles; h++) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                in_last  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                totalCount++;
                if (out_valid !== 1'b1 || out_data !== expData || out_index !== IDX_W'(expIdx) || in_ready !== 1'b0)
                    $display("FAIL %s stall cycle %0d: observed v=%b d=%h i=%0d rdy=%b, required v=1 d=%h i=%0d rdy=0",
                             name, h, out_valid, out_data, out_index, in_ready, expData, expIdx);
                else passCount++;
            end
            in_valid  = 1'b0;
            in_last   = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            totalCount++;
            if (out_valid !== 1'b0) $display("FAIL %s out_valid after pop: observed %b, required 0", name, out_valid);
            else passCount++;
        end
    endtask

    task automatic setGrp(input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
        grpLen = n;
        grp[0] = a; grp[1] = b; grp[2] = c; grp[3] = d;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        totalCount++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_index !== '0)
            $display("FAIL reset state: observed rdy=%b v=%b d=%h i=%0d, required 0 0 00000000 0",
                     in_ready, out_valid, out_data, out_index);
        else passCount++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        totalCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL post-reset: observed rdy=%b v=%b, required rdy=1 v=0", in_ready, out_valid);
        else passCount++;
    endtask

    task automatic test_directed();
        setGrp(4, 32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000);
        runGroup("mixed", 1'b0, 0);
        setGrp(4, 32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000);
        runGroup("negative", 1'b1, 0);
        setGrp(4, 32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000);
        runGroup("zeros_tie", 1'b0, 0);
        setGrp(4, 32'h3F800000, 32'h7FC00001, 32'h7F800000, 32'h00000000);
        runGroup("nan", 1'b0, 0);
        setGrp(4, 32'h7F800000, 32'h7FC00000, 32'hFF800001, 32'h00000000);
        runGroup("nan_first_kept", 1'b0, 0);
        setGrp(2, 32'h00000001, 32'h7F7FFFFF, 32'h0, 32'h0);
        runGroup("early_last", 1'b1, 0);
        setGrp(4, 32'h7F800000, 32'h00000000, 32'h3F800000, 32'h3F800000);
        runGroup("after_early_idx0", 1'b0, 0);
        setGrp(1, 32'hC1200000, 32'h0, 32'h0, 32'h0);
        runGroup("single_elem", 1'b1, 0);
        setGrp(4, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000);
        runGroup("pos_zero_first", 1'b0, 0);
    endtask

    task automatic test_backpressure();
        setGrp(4, 32'h00400000, 32'h00000001, 32'h80400000, 32'h00200000);
        runGroup("backpressure", 1'b0, 5);
    endtask

    task automatic test_reset_in_hold();
        for (int i = 0; i < WINDOW; i++)
            sendElem("reset_hold", 32'h3F800000 + 32'(i), 1'b0);
        in_valid = 1'b0;
        totalCount++;
        if (out_valid !== 1'b1) $display("FAIL reset_hold pre: observed out_valid=%b, required 1", out_valid);
        else passCount++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        totalCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_hold drop: observed v=%b rdy=%b, required v=0 rdy=0", out_valid, in_ready);
        else passCount++;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            totalCount++;
            if (out_valid !== 1'b0) $display("FAIL reset_hold lost: observed out_valid=%b, required 0", out_valid);
            else passCount++;
        end
        // A partial group cut by reset must not leak into the next one.
        sendElem("reset_mid", 32'h7F000000, 1'b0);
        sendElem("reset_mid", 32'h7F000001, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        setGrp(4, 32'hBF800000, 32'h3E800000, 32'h3E000000, 32'hC0000000);
        runGroup("after_mid_reset", 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        setGrp(4, 32'h40400000, 32'h40800000, 32'h40000000, 32'hC0800000);
        runGroup("b2b_0", 1'b0, -1);
        setGrp(3, 32'hFF800000, 32'h80000001, 32'hFF7FFFFF, 32'h0);
        runGroup("b2b_1", 1'b1, -1);
        setGrp(4, 32'h00000003, 32'h00000003, 32'h00000002, 32'h00000003);
        runGroup("b2b_2", 1'b0, -1);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit lastFlag;
        for (int g = 0; g < 60; g++) begin
            grpLen = $urandom_range(1, WINDOW);
            for (int i = 0; i < WINDOW; i++)
                grp[i] = randWord();
            lastFlag = (grpLen < WINDOW) ? 1'b1 : 1'($urandom_range(0, 1));
            runGroup($sformatf("random_%0d", g), lastFlag, $urandom_range(0, 2));
        end
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        grpLen     = 0;
        for (int i = 0; i < WINDOW; i++)
            grp[i] = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_in_hold();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
